fetch_redirect_ctrl: RTL
========================

// Module: fetch_redirect_ctrl
// PURPOSE
// - Sequences redirects into the PC generation stage: arbitrates exception, branch-mispredict and prediction sources.
// - Holds a redirect that arrives while fetch is stalled until fetch can accept it.
// - Flushes in-flight fetch stages for FLUSH_CYCLES cycles after every redirect.
// - Sits between commit/branch unit/predictor and pc_gen_stage; its outputs drive that stage's redirect inputs directly.
// PARAMETERS
// - FLUSH_CYCLES  2   cycles flush_o stays high per redirect, counting the accept cycle; legal range 1..15
// - CNT_W         32  width of statistics counters (only with FETCH_REDIRECT_STATS_EN)
// PORTS
// - clk_i          in   1             clock, rising edge
// - rst_i          in   1             reset, asynchronous, active-high
// - except_i       in   1             exception redirect request
// - except_pc_i    in   XLEN          exception target PC
// - res_i          in   resolution_t  branch resolution {valid,mispredict,taken,pc,target}
// - pred_i         in   prediction_t  branch prediction {taken,target}
// - fetch_ready_i  in   1             PC generation/fetch accepts a new PC this cycle
// - except_o       out  1             exception redirect to PC generation stage
// - except_pc_o    out  XLEN          exception target PC to PC generation stage
// - res_o          out  resolution_t  resolution to PC generation stage
// - pred_o         out  prediction_t  prediction to PC generation stage
// - flush_o        out  1             squash in-flight fetch stages
// - busy_o         out  1             a held redirect is pending (state PEND)
// - exc_cnt_o      out  CNT_W         accepted exceptions (FETCH_REDIRECT_STATS_EN only)
// - misp_cnt_o     out  CNT_W         accepted mispredicts (FETCH_REDIRECT_STATS_EN only)
// BEHAVIOUR
// - Redirect event (rdev) = except_i | (res_i.valid & res_i.mispredict). Priority: exception > mispredict > prediction.
// - States:
//   - IDLE: no redirect pending, no flush running.
//   - PEND: redirect captured, waiting for fetch_ready_i.
//   - FLUSH: post-redirect squash window; flush counter fcnt runs.
// - IDLE, no rdev: except_o=0; res_o=res_i; pred_o=pred_i; flush_o=0.
// - IDLE|FLUSH, rdev & fetch_ready_i: winning redirect forwarded combinationally, 0-cycle latency.
//   - Loser is dropped; pred_o.taken=0; flush_o=1.
//   - Next state: FLUSH with fcnt=FLUSH_CYCLES-1; IDLE if FLUSH_CYCLES==1.
// - IDLE|FLUSH, rdev & !fetch_ready_i: capture winner into hold reg {kind,pc,target,taken}; next state PEND.
// - PEND outputs:
//   - Held redirect is driven every cycle (held mispredict as res_o.valid=1, mispredict=1, taken, pc, target).
//   - pred_o.taken=0; flush_o=1; busy_o=1.
// - PEND inputs:
//   - New except_i overwrites a held mispredict or older exception.
//   - New mispredict is ignored (held branch is older).
// - PEND & fetch_ready_i: held redirect consumed that cycle; next state FLUSH with fcnt=FLUSH_CYCLES-1 (IDLE if 1).
//   - An exception arriving in the same cycle wins over the held redirect and is forwarded instead.
// - FLUSH, no rdev:
//   - flush_o=1; pred_o.taken=0 (predictions come from squashed fetches); res_o=res_i.
//   - fcnt decrements each cycle; fcnt==0 -> IDLE next cycle.
// - FLUSH, rdev: handled as in IDLE; the flush window restarts (fcnt reloaded).
// - rst_i high: state IDLE, hold reg and fcnt cleared.
//   - All outputs 0: except_o, res_o.valid, pred_o.taken, flush_o, busy_o, counters.
//   - Reset asserted mid-PEND discards the held redirect.
// CONFIGURATION
// - `FETCH_REDIRECT_STATS_EN defined:
//   - exc_cnt_o / misp_cnt_o increment once per accepted (forwarded) redirect of that kind.
//   - Counters saturate at all-ones; a held redirect is counted once, when consumed.
// - Not defined: counter ports and logic are absent; all other behaviour is identical.
// STRUCTURE
// - mmm_pkg gains:
//   - redirect_kind_t enum {RD_NONE, RD_EXCEPT, RD_MISPRED}
//   - redirect_t struct {kind, pc, target, taken}
//   - frc_state_t enum {FRC_IDLE, FRC_PEND, FRC_FLUSH}
// - Reuses XLEN, resolution_t and prediction_t from mmm_pkg.
// - One sub-module: sat_counter (CNT_W, inc_i, cnt_o), instantiated twice under the macro.
//   - Arbitration and FSM stay in this file.
// TESTING
// - T1: IDLE, pred_i={1,0x8000_0200}, fetch_ready_i=1 -> pred_o passes through, flush_o=0, state IDLE.
// - T2: res_i={1,1,1,0x100,0x400}, fetch_ready_i=1 -> res_o equals it the same cycle, pred_o.taken=0.
//   - flush_o high for exactly 2 cycles, then IDLE.
// - T3: res_i mispredict with fetch_ready_i=0 for 3 cycles -> busy_o=1, held res_o is stable.
//   - At fetch_ready_i=1 it is forwarded once, then 1 further flush cycle.
// - T4: PEND holding mispredict, except_i=1 with except_pc_i=0x0000_0040 -> held becomes exception.
//   - At accept: except_o=1, except_pc_o=0x40; res_o.mispredict=0.
// - T5: except_i and mispredict together, fetch_ready_i=1 -> only except_o is forwarded.
//   - With stats: exc_cnt_o=1, misp_cnt_o=0.
// - T6: rst_i asserted during PEND -> all outputs 0 immediately (async).
//   - After release: IDLE, no stale redirect forwarded even when fetch_ready_i=1.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared front-end types: branch resolution/prediction records plus the
// redirect-sequencing types used by fetch_redirect_ctrl.
package mmm_pkg;

  localparam int XLEN   = 32;
  localparam int FCNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic            mispredict;
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } resolution_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  typedef enum logic [1:0] {
    RD_NONE    = 2'd0,
    RD_EXCEPT  = 2'd1,
    RD_MISPRED = 2'd2
  } redirect_kind_t;

  typedef struct packed {
    redirect_kind_t  kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } redirect_t;

  typedef enum logic [1:0] {
    FRC_IDLE  = 2'd0,
    FRC_PEND  = 2'd1,
    FRC_FLUSH = 2'd2
  } frc_state_t;

  // Rebuilds the resolution record seen by pc_gen from a held mispredict.
  function automatic resolution_t redirect_to_res(input redirect_t r);
    resolution_t res;
    res.valid      = 1'b1;
    res.mispredict = 1'b1;
    res.taken      = r.taken;
    res.pc         = r.pc;
    res.target     = r.target;
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Arbitrates exception / mispredict / prediction redirects into pc_gen, holds
// redirects across fetch stalls and opens a flush window after each one.
// Optional statistics counters: define FETCH_REDIRECT_STATS_EN.
module fetch_redirect_ctrl
  import mmm_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             except_i,
  input  logic [XLEN-1:0]  except_pc_i,
  input  resolution_t      res_i,
  input  prediction_t      pred_i,
  input  logic             fetch_ready_i,
  output logic             except_o,
  output logic [XLEN-1:0]  except_pc_o,
  output resolution_t      res_o,
  output prediction_t      pred_o,
  output logic             flush_o,
  output logic             busy_o
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [CNT_W-1:0] exc_cnt_o,
  output logic [CNT_W-1:0] misp_cnt_o
`endif
);

  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam frc_state_t POST_ACCEPT = (FLUSH_CYCLES == 1) ? FRC_IDLE : FRC_FLUSH;

  frc_state_t        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  redirect_t         hold_q, hold_d;

  redirect_t win;
  redirect_t drv;
  logic      drv_en;
  logic      acc_exc;
  logic      acc_mis;

  // Fixed-priority pick among the live request sources.
  always_comb begin
    win = '0;
    if (except_i) begin
      win.kind = RD_EXCEPT;
      win.pc   = except_pc_i;
    end else if (res_i.valid && res_i.mispredict) begin
      win.kind   = RD_MISPRED;
      win.pc     = res_i.pc;
      win.target = res_i.target;
      win.taken  = res_i.taken;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    hold_d      = hold_q;
    drv         = '0;
    drv_en      = 1'b0;
    acc_exc     = 1'b0;
    acc_mis     = 1'b0;
    except_o    = 1'b0;
    except_pc_o = except_pc_i;
    res_o       = res_i;
    pred_o      = pred_i;
    flush_o     = 1'b0;
    busy_o      = 1'b0;

    case (state_q)
      FRC_PEND: begin
        // A younger exception replaces whatever is held; new mispredicts are younger than the held branch.
        drv    = (win.kind == RD_EXCEPT) ? win : hold_q;
        drv_en = 1'b1;
        busy_o = 1'b1;
        if (!fetch_ready_i) begin
          hold_d = drv;
        end
      end
      default: begin
        if (win.kind != RD_NONE) begin
          drv    = win;
          drv_en = 1'b1;
          if (!fetch_ready_i) begin
            hold_d  = win;
            state_d = FRC_PEND;
          end
        end else if (state_q == FRC_FLUSH) begin
          flush_o       = 1'b1;
          pred_o.taken  = 1'b0;
          fcnt_d        = fcnt_q - 1'b1;
          if (fcnt_q <= FCNT_W'(1)) begin
            fcnt_d  = '0;
            state_d = FRC_IDLE;
          end
        end
      end
    endcase

    if (drv_en) begin
      flush_o      = 1'b1;
      pred_o.taken = 1'b0;
      if (drv.kind == RD_EXCEPT) begin
        except_o    = 1'b1;
        except_pc_o = drv.pc;
        res_o       = '0;
      end else begin
        res_o = redirect_to_res(drv);
      end
      if (fetch_ready_i) begin
        acc_exc = (drv.kind == RD_EXCEPT);
        acc_mis = (drv.kind == RD_MISPRED);
        hold_d  = '0;
        fcnt_d  = FCNT_LOAD;
        state_d = POST_ACCEPT;
      end
    end

    // Outputs go quiet the moment reset rises, not at the next edge.
    if (rst_i) begin
      except_o    = 1'b0;
      except_pc_o = '0;
      res_o       = '0;
      pred_o      = '0;
      flush_o     = 1'b0;
      busy_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FRC_IDLE;
      fcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      hold_q  <= hold_d;
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_exc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (acc_exc),
    .cnt_o (exc_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_misp_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (acc_mis),
    .cnt_o (misp_cnt_o)
  );
`else
  localparam int UNUSED_CNT_W = CNT_W;
  logic unused_stats;
  assign unused_stats = acc_exc ^ acc_mis;
`endif

endmodule
